// File: rtl/countdown_sequencer.sv
// Control sequencer for the countdown datapath: arbitrates button pulses, queues setup edits, issues ADD/SUB/DEC1 commands.
// Latency: an accepted edit appears on dp_valid the next cycle when idle; a tick's DEC1 appears the cycle after the tick count wraps.
// Backpressure: one command outstanding, held stable until dp_ready; edits beyond 2 queued are dropped; a tick that finds DEC1 still waiting is discarded and latches overrun.
module countdown_sequencer #(
    parameter int CYC    = 50000000,
    parameter int STEP_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sp_pulse,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic [STEP_W-1:0] step,
    input  logic              dp_zero,
    input  logic              dp_ready,
    output logic              dp_valid,
    output logic [1:0]        dp_op,
    output logic [STEP_W-1:0] dp_step,
    output logic [1:0]        state,
    output logic              led_blink,
    output logic              overrun
);

    localparam int CNT_W = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_HALF = CNT_W'(CYC / 2);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_DEC1 = 2'd2;

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                start_pending_q, start_pending_d;
    logic [1:0]          fifo_op_q [2];
    logic [1:0]          fifo_op_d [2];
    logic [STEP_W-1:0]   fifo_step_q [2];
    logic [STEP_W-1:0]   fifo_step_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                dp_valid_q, dp_valid_d;
    logic [1:0]          dp_op_q, dp_op_d;
    logic [STEP_W-1:0]   dp_step_q, dp_step_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                led_blink_q, led_blink_d;
    logic                overrun_q, overrun_d;

    logic                inc_acc, dec_acc, push, pop, busy, tick;
    logic [1:0]          push_op;
    logic [1:0]          cnt_after_pop;

    // Arbitration, edit queue, command register, tick/blink counters and FSM next state.
    always_comb begin
        state_d         = state_q;
        start_pending_d = start_pending_q;
        fifo_op_d       = fifo_op_q;
        fifo_step_d     = fifo_step_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        dp_valid_d      = dp_valid_q;
        dp_op_d         = dp_op_q;
        dp_step_d       = dp_step_q;
        tick_cnt_d      = tick_cnt_q;
        blink_cnt_d     = '0;
        overrun_d       = overrun_q;

        // sp beats inc beats dec; losers are simply dropped
        inc_acc = inc_pulse & ~sp_pulse;
        dec_acc = dec_pulse & ~sp_pulse & ~inc_pulse;
        push_op = inc_acc ? OP_ADD : OP_SUB;
        push    = (state_q == ST_SETUP) & ~start_pending_q & (inc_acc | dec_acc)
                  & (fifo_cnt_q != 2'd2);
        // presented command stays put next cycle
        busy    = dp_valid_q & ~dp_ready;
        // only queued edits live in the FIFO; DEC1 is injected straight into the command register
        pop     = dp_valid_q & dp_ready & (dp_op_q != OP_DEC1);
        tick    = (state_q == ST_RUN) & (tick_cnt_q == CNT_LAST);

        if (push) begin
            fifo_op_d[wr_ptr_q]   = push_op;
            fifo_step_d[wr_ptr_q] = step;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_after_pop = fifo_cnt_q - {1'b0, pop};
        fifo_cnt_d    = cnt_after_pop + {1'b0, push};

        // Load the next command once the current one is gone; new edits bypass straight in when idle
        if (!busy) begin
            if (tick) begin
                dp_valid_d = 1'b1;
                dp_op_d    = OP_DEC1;
                dp_step_d  = '0;
            end else if (cnt_after_pop != 2'd0) begin
                dp_valid_d = 1'b1;
                dp_op_d    = fifo_op_q[rd_ptr_d];
                dp_step_d  = fifo_step_q[rd_ptr_d];
            end else if (push) begin
                dp_valid_d = 1'b1;
                dp_op_d    = push_op;
                dp_step_d  = step;
            end else begin
                dp_valid_d = 1'b0;
                dp_op_d    = '0;
                dp_step_d  = '0;
            end
        end else if (tick) begin
            overrun_d = 1'b1;
        end

        if (state_q == ST_RUN) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_SETUP: begin
                if (sp_pulse || start_pending_q) begin
                    if ((fifo_cnt_q == 2'd0) && !dp_valid_q) begin
                        start_pending_d = 1'b0;
                        if (!dp_zero) begin
                            state_d    = ST_RUN;
                            tick_cnt_d = '0;
                        end
                    end else begin
                        start_pending_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (sp_pulse) begin
                    state_d = ST_PAUSE;
                end else if (dp_zero && !dp_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (sp_pulse) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (sp_pulse) begin
                    state_d = ST_SETUP;
                end else begin
                    blink_cnt_d = (blink_cnt_q == CNT_LAST) ? '0 : blink_cnt_q + 1'b1;
                end
            end
        endcase

        // registered so the LED tracks the blink count seen in the same cycle
        led_blink_d = (state_d == ST_DONE) && (blink_cnt_d >= BLINK_HALF);
    end

    // State registers; rst discards everything, including an outstanding command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_SETUP;
            start_pending_q <= 1'b0;
            fifo_op_q[0]    <= '0;
            fifo_op_q[1]    <= '0;
            fifo_step_q[0]  <= '0;
            fifo_step_q[1]  <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            fifo_cnt_q      <= '0;
            dp_valid_q      <= 1'b0;
            dp_op_q         <= '0;
            dp_step_q       <= '0;
            tick_cnt_q      <= '0;
            blink_cnt_q     <= '0;
            led_blink_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_pending_q <= start_pending_d;
            fifo_op_q       <= fifo_op_d;
            fifo_step_q     <= fifo_step_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            fifo_cnt_q      <= fifo_cnt_d;
            dp_valid_q      <= dp_valid_d;
            dp_op_q         <= dp_op_d;
            dp_step_q       <= dp_step_d;
            tick_cnt_q      <= tick_cnt_d;
            blink_cnt_q     <= blink_cnt_d;
            led_blink_q     <= led_blink_d;
            overrun_q       <= overrun_d;
        end
    end

    assign dp_valid  = dp_valid_q;
    assign dp_op     = dp_op_q;
    assign dp_step   = dp_step_q;
    assign state     = state_q;
    assign led_blink = led_blink_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer with CYC=10: edit queueing, ticks, pause/resume, DONE blink, overrun, reset.
// Expected commands are queued when stimulus is driven and compared at each dp_valid & dp_ready transfer.
// Inputs change 1 time unit after the rising edge; transfers are observed on the falling edge.
module tb_countdown_sequencer;

    localparam int CYC    = 10;
    localparam int STEP_W = 11;

    typedef struct packed {
        logic [1:0]        op;
        logic [STEP_W-1:0] step;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              sp_pulse, inc_pulse, dec_pulse;
    logic [STEP_W-1:0] step;
    logic              dp_zero, dp_ready;
    logic              dp_valid;
    logic [1:0]        dp_op;
    logic [STEP_W-1:0] dp_step;
    logic [1:0]        state;
    logic              led_blink, overrun;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   xfer_cnt = 0;
    int   extra_cnt = 0;
    int   n;
    int   xfer_before;
    cmd_t exp_q[$];
    cmd_t mon_e;

    countdown_sequencer #(.CYC(CYC), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sp_pulse  (sp_pulse),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .step      (step),
        .dp_zero   (dp_zero),
        .dp_ready  (dp_ready),
        .dp_valid  (dp_valid),
        .dp_op     (dp_op),
        .dp_step   (dp_step),
        .state     (state),
        .led_blink (led_blink),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] op, input logic [STEP_W-1:0] st);
        mk = {op, st};
    endfunction

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // steps at least once, then until dp_valid is seen or the budget runs out
    task automatic wait_valid(output int cnt, input int limit);
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (!dp_valid && cnt < limit);
    endtask

    task automatic pulse_sp();
        sp_pulse = 1'b1;
        cyc(1);
        sp_pulse = 1'b0;
    endtask

    task automatic pulse_edit(input bit is_inc, input int val);
        step      = STEP_W'(val);
        inc_pulse = is_inc;
        dec_pulse = ~is_inc;
        cyc(1);
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
    endtask

    // Scoreboard: every transfer is matched against the oldest expected command
    always @(negedge clk) begin
        if (!rst && dp_valid && dp_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                extra_cnt++;
            end else begin
                mon_e = exp_q.pop_front();
                check_val("xfer_op", 32'(dp_op), 32'(mon_e.op));
                check_val("xfer_step", 32'(dp_step), 32'(mon_e.step));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sp_pulse = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
        step = '0; dp_zero = 1'b0; dp_ready = 1'b1;
        cyc(2);
        check_val("rst_state", 32'(state), 0);
        check_val("rst_valid", 32'(dp_valid), 0);
        check_val("rst_op", 32'(dp_op), 0);
        check_val("rst_step", 32'(dp_step), 0);
        check_val("rst_led", 32'(led_blink), 0);
        check_val("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        cyc(2);

        // single ADD with the datapath ready
        exp_q.push_back(mk(2'd0, 11'd60));
        pulse_edit(1'b1, 60);
        check_val("add60_valid", 32'(dp_valid), 1);
        check_val("add60_op", 32'(dp_op), 0);
        check_val("add60_step", 32'(dp_step), 60);
        cyc(1);
        check_val("add60_single", 32'(dp_valid), 0);

        // fill the 2-entry queue while stalled; third edit is dropped
        dp_ready = 1'b0;
        exp_q.push_back(mk(2'd0, 11'd5));
        pulse_edit(1'b1, 5);
        exp_q.push_back(mk(2'd1, 11'd3));
        pulse_edit(1'b0, 3);
        pulse_edit(1'b1, 7);
        check_val("q_head_step", 32'(dp_step), 5);
        dp_ready = 1'b1;
        cyc(1);
        check_val("q_b2b_valid", 32'(dp_valid), 1);
        check_val("q_b2b_op", 32'(dp_op), 1);
        check_val("q_b2b_step", 32'(dp_step), 3);
        cyc(2);
        check_val("q_drained", 32'(dp_valid), 0);
        check_val("q_sb_empty", exp_q.size(), 0);

        // RUN: DEC1 every CYC cycles
        pulse_sp();
        check_val("run_state", 32'(state), 1);
        exp_q.push_back(mk(2'd2, 11'd0));
        wait_valid(n, 40);
        check_val("tick1_period", n, 10);
        exp_q.push_back(mk(2'd2, 11'd0));
        wait_valid(n, 40);
        check_val("tick2_period", n, 10);

        // pause four cycles into a second, resume, finish the partial second
        cyc(4);
        pulse_sp();
        check_val("pause_state", 32'(state), 2);
        cyc(20);
        check_val("pause_hold_state", 32'(state), 2);
        check_val("pause_no_tick", 32'(dp_valid), 0);
        exp_q.push_back(mk(2'd2, 11'd0));
        pulse_sp();
        wait_valid(n, 40);
        check_val("resume_tick", n + 1, 6);

        // count reaches zero with nothing outstanding -> DONE and blink
        cyc(1);
        dp_zero = 1'b1;
        check_val("zero_still_run", 32'(state), 1);
        cyc(1);
        check_val("done_state", 32'(state), 3);
        for (int i = 0; i < 20; i++) begin
            check_val($sformatf("blink_%0d", i), 32'(led_blink), ((i % 10) >= 5) ? 1 : 0);
            cyc(1);
        end
        pulse_sp();
        check_val("done_to_setup", 32'(state), 0);
        check_val("setup_led_off", 32'(led_blink), 0);

        // start at zero is refused
        pulse_sp();
        check_val("start_zero_refused", 32'(state), 0);

        // simultaneous sp/inc/dec: start wins, nothing queued
        dp_zero = 1'b0;
        step = 11'd33;
        sp_pulse = 1'b1; inc_pulse = 1'b1; dec_pulse = 1'b1;
        cyc(1);
        sp_pulse = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
        check_val("all3_state", 32'(state), 1);
        check_val("all3_nothing_queued", 32'(dp_valid), 0);

        // stalled datapath across several ticks -> overrun, one DEC1 survives
        dp_ready = 1'b0;
        cyc(25);
        check_val("ovr_set", 32'(overrun), 1);
        check_val("ovr_held_valid", 32'(dp_valid), 1);
        check_val("ovr_held_op", 32'(dp_op), 2);
        exp_q.push_back(mk(2'd2, 11'd0));
        xfer_before = xfer_cnt;
        dp_ready = 1'b1;
        cyc(3);
        check_val("ovr_one_xfer", xfer_cnt - xfer_before, 1);
        check_val("ovr_idle", 32'(dp_valid), 0);
        check_val("ovr_sticky", 32'(overrun), 1);

        // async reset mid-RUN, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_state", 32'(state), 0);
        check_val("arst_valid", 32'(dp_valid), 0);
        check_val("arst_op", 32'(dp_op), 0);
        check_val("arst_overrun", 32'(overrun), 0);
        check_val("arst_led", 32'(led_blink), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1);

        // start requested with an edit in flight: waits for the drain, edits ignored meanwhile
        dp_ready = 1'b0;
        exp_q.push_back(mk(2'd0, 11'd9));
        pulse_edit(1'b1, 9);
        check_val("pend_head_step", 32'(dp_step), 9);
        pulse_sp();
        pulse_edit(1'b0, 4);
        check_val("pend_wait_state", 32'(state), 0);
        dp_ready = 1'b1;
        cyc(2);
        check_val("pend_run_state", 32'(state), 1);
        check_val("pend_no_extra_cmd", 32'(dp_valid), 0);

        cyc(2);
        check_val("sb_leftover", exp_q.size(), 0);
        check_val("sb_extra_xfers", extra_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
